// File: rtl/cin_merger.sv
// cin_merger: packs pairs of half-width feature beats into full-width words.
// The first beat of a pair is held and becomes the low half of the word; the
// second beat becomes the high half. A tile that ends on a low beat is flushed
// as a word whose high half is zero. Finished words go through a 2-entry
// buffer, so S_Ready is derived from registered occupancy only and never
// combinationally from M_Ready.
module cin_merger #(
  parameter int PICTURE_NUM     = 1,
  parameter int CHANNEL_OUT_NUM = 8,
  localparam int HALF_W         = PICTURE_NUM * CHANNEL_OUT_NUM * 4,
  localparam int FULL_W         = 2 * HALF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HALF_W-1:0] S_Feature,
  input  logic              S_Valid,
  input  logic              S_Last,
  output logic              S_Ready,
  output logic [FULL_W-1:0] M_Feature,
  output logic              M_Valid,
  output logic              M_Last,
  input  logic              M_Ready
);

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_t;

  phase_t              phase_r;
  phase_t              phase_nxt_s;
  logic [HALF_W-1:0]   hold_r;
  logic [HALF_W-1:0]   hold_nxt_s;

  // Output buffer: head entry drives the M_* outputs, tail entry is the spare.
  logic [FULL_W-1:0]   head_word_r;
  logic                head_last_r;
  logic [FULL_W-1:0]   tail_word_r;
  logic                tail_last_r;
  logic [1:0]          count_r;
  logic                valid_r;

  logic [FULL_W-1:0]   head_word_nxt_s;
  logic                head_last_nxt_s;
  logic [FULL_W-1:0]   tail_word_nxt_s;
  logic                tail_last_nxt_s;
  logic [1:0]          count_nxt_s;

  logic                ready_s;
  logic                in_xfer_s;
  logic                out_xfer_s;
  logic                push_s;
  logic [FULL_W-1:0]   push_word_s;
  logic                push_last_s;

  // Ready comes from buffer occupancy alone and is forced low during reset.
  assign ready_s    = !rst && (count_r < 2'd2);
  assign in_xfer_s  = S_Valid && ready_s;
  assign out_xfer_s = valid_r && M_Ready;

  assign S_Ready   = ready_s;
  assign M_Valid   = valid_r;
  assign M_Feature = head_word_r;
  assign M_Last    = head_last_r;

  // Pairing: decide whether an accepted beat is held or completes a word.
  always_comb begin
    phase_nxt_s = phase_r;
    hold_nxt_s  = hold_r;
    push_s      = 1'b0;
    push_word_s = {FULL_W{1'b0}};
    push_last_s = 1'b0;
    if (in_xfer_s) begin
      case (phase_r)
        PH_LOW: begin
          if (S_Last) begin
            // Odd tile: flush the lone beat with a zero high half.
            push_s      = 1'b1;
            push_word_s = {{HALF_W{1'b0}}, S_Feature};
            push_last_s = 1'b1;
            phase_nxt_s = PH_LOW;
          end else begin
            hold_nxt_s  = S_Feature;
            phase_nxt_s = PH_HIGH;
          end
        end
        PH_HIGH: begin
          push_s      = 1'b1;
          push_word_s = {S_Feature, hold_r};
          push_last_s = S_Last;
          phase_nxt_s = PH_LOW;
        end
        default: begin
          phase_nxt_s = PH_LOW;
        end
      endcase
    end else begin
      phase_nxt_s = phase_r;
      hold_nxt_s  = hold_r;
    end
  end

  // Buffer update: push and pop may happen together; a pop promotes the tail.
  always_comb begin
    head_word_nxt_s = head_word_r;
    head_last_nxt_s = head_last_r;
    tail_word_nxt_s = tail_word_r;
    tail_last_nxt_s = tail_last_r;
    count_nxt_s     = count_r;
    case (count_r)
      2'd0: begin
        if (push_s) begin
          head_word_nxt_s = push_word_s;
          head_last_nxt_s = push_last_s;
          count_nxt_s     = 2'd1;
        end else begin
          count_nxt_s     = 2'd0;
        end
      end
      2'd1: begin
        case ({push_s, out_xfer_s})
          2'b11: begin
            head_word_nxt_s = push_word_s;
            head_last_nxt_s = push_last_s;
            count_nxt_s     = 2'd1;
          end
          2'b10: begin
            tail_word_nxt_s = push_word_s;
            tail_last_nxt_s = push_last_s;
            count_nxt_s     = 2'd2;
          end
          2'b01: begin
            count_nxt_s     = 2'd0;
          end
          default: begin
            count_nxt_s     = 2'd1;
          end
        endcase
      end
      2'd2: begin
        // Input is stalled when full, so only a pop can occur here.
        if (out_xfer_s) begin
          head_word_nxt_s = tail_word_r;
          head_last_nxt_s = tail_last_r;
          count_nxt_s     = 2'd1;
        end else begin
          count_nxt_s     = 2'd2;
        end
      end
      default: begin
        count_nxt_s = 2'd0;
      end
    endcase
  end

  // Pairing state registers; reset discards any held low half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r <= PH_LOW;
      hold_r  <= {HALF_W{1'b0}};
    end else begin
      phase_r <= phase_nxt_s;
      hold_r  <= hold_nxt_s;
    end
  end

  // Buffer registers; reset drops every buffered word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_word_r <= {FULL_W{1'b0}};
      head_last_r <= 1'b0;
      tail_word_r <= {FULL_W{1'b0}};
      tail_last_r <= 1'b0;
      count_r     <= 2'd0;
      valid_r     <= 1'b0;
    end else begin
      head_word_r <= head_word_nxt_s;
      head_last_r <= head_last_nxt_s;
      tail_word_r <= tail_word_nxt_s;
      tail_last_r <= tail_last_nxt_s;
      count_r     <= count_nxt_s;
      valid_r     <= (count_nxt_s != 2'd0);
    end
  end

endmodule
